// File: rtl/tpg_timing_ctrl_pkg.sv
// Shared constants and types for the TPG timing-configuration controller.
package tpg_pkg;

    // Shadow register map (cfg_addr values)
    localparam logic [3:0] A_HS_START   = 4'd0;
    localparam logic [3:0] A_HS_END     = 4'd1;
    localparam logic [3:0] A_HACT_START = 4'd2;
    localparam logic [3:0] A_HACT_END   = 4'd3;
    localparam logic [3:0] A_H_END      = 4'd4;
    localparam logic [3:0] A_VS_START   = 4'd5;
    localparam logic [3:0] A_VS_END     = 4'd6;
    localparam logic [3:0] A_VACT_START = 4'd7;
    localparam logic [3:0] A_VACT_END   = 4'd8;
    localparam logic [3:0] A_V_END      = 4'd9;
    localparam logic [3:0] N_REGS       = 4'd10;

    // Index of each field inside a 5-entry horizontal or vertical group
    localparam int unsigned I_SYNC_START = 0;
    localparam int unsigned I_SYNC_END   = 1;
    localparam int unsigned I_ACT_START  = 2;
    localparam int unsigned I_ACT_END    = 3;
    localparam int unsigned I_TOTAL_END  = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_PEND     = 3'd2,
        ST_RUN      = 3'd3,
        ST_STOPPING = 3'd4
    } state_e;

endpackage

// File: rtl/tpg_timing_ctrl_if.sv
// Configuration port between the CPU/register side and the timing controller.
interface tpg_timing_ctrl_if #(
    parameter int DW = 16
);
    logic          cfg_wr;
    logic [3:0]    cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          cfg_commit;
    logic          cfg_stop;
    logic          cfg_busy;
    logic          commit_done;
    logic          cfg_err;

    modport master (
        output cfg_wr, cfg_addr, cfg_wdata, cfg_commit, cfg_stop,
        input  cfg_busy, commit_done, cfg_err
    );

    modport slave (
        input  cfg_wr, cfg_addr, cfg_wdata, cfg_commit, cfg_stop,
        output cfg_busy, commit_done, cfg_err
    );
endinterface

// File: rtl/tpg_timing_regs.sv
// Shadow timing bank: address decode, write rejection and set validity check.
module tpg_timing_regs
    import tpg_pkg::*;
#(
    parameter int H_BITS = 12,
    parameter int V_BITS = 12,
    parameter int DW     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_i,
    input  logic                     busy_i,
    input  logic [3:0]               addr_i,
    input  logic [DW-1:0]            wdata_i,
    output logic                     wr_err_o,
    output logic                     valid_o,
    output logic [4:0][H_BITS-1:0]   h_o,
    output logic [4:0][V_BITS-1:0]   v_o
);

    logic [4:0][H_BITS-1:0] h_q, h_d;
    logic [4:0][V_BITS-1:0] v_q, v_d;
    logic                   wr_ok_s;
    logic [H_BITS-1:0]      wh_s;
    logic [V_BITS-1:0]      wv_s;

    assign wr_ok_s  = wr_i && !busy_i && (addr_i < N_REGS);
    assign wr_err_o = wr_i && !wr_ok_s;
    assign wh_s     = H_BITS'(wdata_i);
    assign wv_s     = V_BITS'(wdata_i);

    // Decode an accepted write into the matching shadow field
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (wr_ok_s) begin
            case (addr_i)
                A_HS_START:   h_d[I_SYNC_START] = wh_s;
                A_HS_END:     h_d[I_SYNC_END]   = wh_s;
                A_HACT_START: h_d[I_ACT_START]  = wh_s;
                A_HACT_END:   h_d[I_ACT_END]    = wh_s;
                A_H_END:      h_d[I_TOTAL_END]  = wh_s;
                A_VS_START:   v_d[I_SYNC_START] = wv_s;
                A_VS_END:     v_d[I_SYNC_END]   = wv_s;
                A_VACT_START: v_d[I_ACT_START]  = wv_s;
                A_VACT_END:   v_d[I_ACT_END]    = wv_s;
                A_V_END:      v_d[I_TOTAL_END]  = wv_s;
                default: begin
                    h_d = h_q;
                    v_d = v_q;
                end
            endcase
        end else begin
            h_d = h_q;
            v_d = v_q;
        end
    end

    // Shadow register storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // A set is usable only with non-degenerate totals and active regions inside them
    assign valid_o = (h_q[I_TOTAL_END] >= H_BITS'(2)) &&
                     (v_q[I_TOTAL_END] >= V_BITS'(2)) &&
                     (h_q[I_ACT_END] <= h_q[I_TOTAL_END]) &&
                     (v_q[I_ACT_END] <= v_q[I_TOTAL_END]);

    assign h_o = h_q;
    assign v_o = v_q;

endmodule

// File: rtl/tpg_timing_ctrl.sv
// Timing-configuration controller: commit FSM, active timing set, enable and frame counter.
module tpg_timing_ctrl
    import tpg_pkg::*;
#(
    parameter int H_BITS = 12,
    parameter int V_BITS = 12,
    parameter int DW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    tpg_timing_ctrl_if.slave  cfg,
    input  logic              vs_in,
    output logic              tpg_en,
    output logic [H_BITS-1:0] tHS_START,
    output logic [H_BITS-1:0] tHS_END,
    output logic [H_BITS-1:0] tHACT_START,
    output logic [H_BITS-1:0] tHACT_END,
    output logic [H_BITS-1:0] tH_END,
    output logic [V_BITS-1:0] tVS_START,
    output logic [V_BITS-1:0] tVS_END,
    output logic [V_BITS-1:0] tVACT_START,
    output logic [V_BITS-1:0] tVACT_END,
    output logic [V_BITS-1:0] tV_END,
    output logic [15:0]       frame_cnt
);

    state_e                 state_q, state_d;
    logic                   from_run_q, from_run_d;
    logic                   vs_d_q;
    logic                   tpg_en_q, tpg_en_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic                   commit_done_q, commit_done_d;
    logic                   cfg_err_q, cfg_err_d;
    logic                   busy_q, busy_d;
    logic [4:0][H_BITS-1:0] act_h_q, act_h_d;
    logic [4:0][V_BITS-1:0] act_v_q, act_v_d;

    logic                   vs_rise_s;
    logic                   wr_err_s;
    logic                   valid_s;
    logic [4:0][H_BITS-1:0] sh_h_s;
    logic [4:0][V_BITS-1:0] sh_v_s;

    tpg_timing_regs #(
        .H_BITS (H_BITS),
        .V_BITS (V_BITS),
        .DW     (DW)
    ) u_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_i     (cfg.cfg_wr),
        .busy_i   (busy_q),
        .addr_i   (cfg.cfg_addr),
        .wdata_i  (cfg.cfg_wdata),
        .wr_err_o (wr_err_s),
        .valid_o  (valid_s),
        .h_o      (sh_h_s),
        .v_o      (sh_v_s)
    );

    assign vs_rise_s = vs_in & ~vs_d_q;

    // Next-state, active-set load and pulse generation
    always_comb begin
        state_d       = state_q;
        from_run_d    = from_run_q;
        tpg_en_d      = tpg_en_q;
        act_h_d       = act_h_q;
        act_v_d       = act_v_q;
        commit_done_d = 1'b0;
        cfg_err_d     = wr_err_s;
        if (vs_rise_s && tpg_en_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        case (state_q)
            ST_IDLE: begin
                // A stop request has nothing to stop here, so only commit matters
                if (cfg.cfg_commit) begin
                    state_d    = ST_CHECK;
                    from_run_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (!valid_s) begin
                    cfg_err_d = 1'b1;
                    state_d   = from_run_q ? ST_RUN : ST_IDLE;
                end else if (from_run_q) begin
                    state_d = ST_PEND;
                end else begin
                    act_h_d       = sh_h_s;
                    act_v_d       = sh_v_s;
                    commit_done_d = 1'b1;
                    tpg_en_d      = 1'b1;
                    frame_cnt_d   = 16'd0;
                    state_d       = ST_RUN;
                end
            end
            ST_RUN: begin
                // Stop has priority; a simultaneous commit is dropped
                if (cfg.cfg_stop) begin
                    state_d = ST_STOPPING;
                end else if (cfg.cfg_commit) begin
                    state_d    = ST_CHECK;
                    from_run_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PEND: begin
                if (vs_rise_s) begin
                    act_h_d       = sh_h_s;
                    act_v_d       = sh_v_s;
                    commit_done_d = 1'b1;
                    state_d       = ST_RUN;
                end else begin
                    state_d = ST_PEND;
                end
            end
            ST_STOPPING: begin
                if (vs_rise_s) begin
                    tpg_en_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_STOPPING;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tpg_en_d = 1'b0;
            end
        endcase
        busy_d = (state_d == ST_CHECK) || (state_d == ST_PEND) || (state_d == ST_STOPPING);
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            from_run_q    <= 1'b0;
            vs_d_q        <= 1'b0;
            tpg_en_q      <= 1'b0;
            frame_cnt_q   <= 16'd0;
            commit_done_q <= 1'b0;
            cfg_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            act_h_q       <= '0;
            act_v_q       <= '0;
        end else begin
            state_q       <= state_d;
            from_run_q    <= from_run_d;
            vs_d_q        <= vs_in;
            tpg_en_q      <= tpg_en_d;
            frame_cnt_q   <= frame_cnt_d;
            commit_done_q <= commit_done_d;
            cfg_err_q     <= cfg_err_d;
            busy_q        <= busy_d;
            act_h_q       <= act_h_d;
            act_v_q       <= act_v_d;
        end
    end

    assign cfg.cfg_busy    = busy_q;
    assign cfg.commit_done = commit_done_q;
    assign cfg.cfg_err     = cfg_err_q;
    assign tpg_en          = tpg_en_q;
    assign frame_cnt       = frame_cnt_q;
    assign tHS_START       = act_h_q[I_SYNC_START];
    assign tHS_END         = act_h_q[I_SYNC_END];
    assign tHACT_START     = act_h_q[I_ACT_START];
    assign tHACT_END       = act_h_q[I_ACT_END];
    assign tH_END          = act_h_q[I_TOTAL_END];
    assign tVS_START       = act_v_q[I_SYNC_START];
    assign tVS_END         = act_v_q[I_SYNC_END];
    assign tVACT_START     = act_v_q[I_ACT_START];
    assign tVACT_END       = act_v_q[I_ACT_END];
    assign tV_END          = act_v_q[I_TOTAL_END];

endmodule

// File: doc/tpg_timing_ctrl.md
# tpg_timing_ctrl

Timing-configuration controller for the test pattern generator. It holds shadow copies of the ten raster timing values, loaded over a simple write port. On a commit it copies them atomically into the active set that drives the generator; in the running state the copy happens only at a frame boundary (rising vsync). It also gates the generator with an enable and counts frames, sitting between the register/CPU side and the pattern generator.

## Interface
- H_BITS, 12, width of horizontal timing values
- V_BITS, 12, width of vertical timing values
- DW, 16, config write data width (≥ max(H_BITS,V_BITS))

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_wr  in  1  shadow write strobe
- cfg_addr  in  4  shadow register index
- cfg_wdata  in  DW  write data, LSBs used
- cfg_commit  in  1  request transfer shadow→active
- cfg_stop  in  1  request generator stop at next frame boundary
- cfg_busy  out  1  commit/stop pending
- commit_done  out  1  1-cycle pulse, active set updated
- cfg_err  out  1  1-cycle pulse, rejected write or commit
- vs_in  in  1  vsync from generator
- tpg_en  out  1  generator enable (run)
- tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END  out  H_BITS  active horizontal timing
- tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END  out  V_BITS  active vertical timing
- frame_cnt  out  16  frames since enable

## Operation
- Address map: 0 HS_START, 1 HS_END, 2 HACT_START, 3 HACT_END, 4 H_END, 5 VS_START, 6 VS_END, 7 VACT_START, 8 VACT_END, 9 V_END. Data truncated to field width.
- cfg_wr rules:
  - addr ≥ 10 → ignored, cfg_err.
  - cfg_busy=1 → ignored, cfg_err.
- States: IDLE, CHECK, PEND, RUN, STOPPING.
- IDLE: tpg_en=0.
  - cfg_commit → CHECK.
- CHECK (1 cycle): valid iff shadow H_END ≥ 2, V_END ≥ 2, HACT_END ≤ H_END, VACT_END ≤ V_END.
  - Invalid → cfg_err, return to previous state (IDLE or RUN), active set unchanged.
  - Valid from IDLE → load active, commit_done, tpg_en=1, frame_cnt cleared, → RUN.
  - Valid from RUN → PEND.
- RUN:
  - cfg_commit → CHECK.
  - cfg_stop → STOPPING.
- PEND: on vs_rise load active, commit_done → RUN.
- STOPPING: on vs_rise tpg_en=0 → IDLE. Active set retained.
- cfg_busy=1 in CHECK, PEND, STOPPING; cfg_commit/cfg_stop ignored while busy.
- Simultaneous events:
  - cfg_stop and cfg_commit in same cycle: stop wins, commit dropped silently.
  - cfg_wr and cfg_commit in same cycle (not busy): write lands first, CHECK sees it.
  - cfg_stop in IDLE: ignored.
- vs_rise = vs_in & ~vs_d, vs_d registered (vs_in synchronous to clk).
- frame_cnt: +1 on each vs_rise while tpg_en=1; wraps 0xFFFF→0.

## Timing
- Reset values: all shadow/active fields 0, tpg_en 0, frame_cnt 0, cfg_busy 0, commit_done 0, cfg_err 0, vs_d 0, state IDLE.
- Commit from IDLE: cfg_commit at cycle N → CHECK at N+1 → active outputs, commit_done, tpg_en all change at N+2.
- Commit from RUN: CHECK at N+1, PEND from N+2.
  - vs_rise visible in cycle M → active outputs and commit_done at M+1.
  - vs_rise in CHECK cycle not used; wait for next.
- Stop: vs_rise in cycle M → tpg_en=0 at M+1. frame_cnt also increments for that edge.
- Reset asserted mid-operation: immediate return to reset values, pending commit lost.
- Outputs registered; no combinational path from cfg_* to any output.

## Structure
- Package tpg_pkg:
  - address constants (A_HS_START…A_V_END, N_REGS=10)
  - state enum
  - timing-set struct parameterised by H_BITS/V_BITS (if tooling allows, else flat vectors)
- Sub-module tpg_timing_regs: shadow bank, address decode, validity check. Controller FSM, active set and frame counter at top.

## Test plan
- Reset, write H_END=800, V_END=525 and other fields, commit from IDLE → tpg_en=1 and tH_END=800 two cycles after commit, commit_done pulse, frame_cnt=0.
- RUN, write H_END=1000, commit; outputs hold 800 until vs_rise, then 1000 next cycle with commit_done; cfg_busy high throughout PEND.
- Commit with shadow H_END=1 or HACT_END=900>H_END=800 → cfg_err at CHECK, active unchanged, state returns to RUN/IDLE.
- Write to addr 12, and write while PEND → cfg_err each, shadow unchanged.
- Same-cycle cfg_stop+cfg_commit in RUN → STOPPING, no commit_done; tpg_en=0 cycle after next vs_rise.
- Drive 65537 vs_rise in RUN → frame_cnt=1. Async rst_n pulse in PEND → all outputs to reset values immediately.
